// File: rtl/tile_colour_renderer.sv
// tile_colour_renderer: 40x30 tile map with a 3-stage pixel lookup pipeline
// and a sweep FSM that clears the map after reset or on request.
module tile_colour_renderer #(
   parameter logic [7:0] COL_EMPTY = 8'h00,
   parameter logic [7:0] COL_BODY  = 8'h1C,
   parameter logic [7:0] COL_HEAD  = 8'h1F,
   parameter logic [7:0] COL_FOOD  = 8'hE0,
   parameter logic [7:0] COL_EDGE  = 8'h92
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [9:0] ADDRH,
   input  logic [8:0] ADDRV,
   output logic [7:0] COLOUR,
   input  logic       WR_EN,
   input  logic [5:0] WR_X,
   input  logic [4:0] WR_Y,
   input  logic [1:0] WR_DATA,
   input  logic       CLEAR,
   output logic       WR_READY
);
   typedef enum logic {ST_IDLE, ST_CLEAR} state_t;
   state_t      state_q, state_d;
   logic [10:0] cnt_q, cnt_d;
   logic        we;
   logic [10:0] wa;
   logic [1:0]  wd;
   logic [1:0]  mem [0:1199];
   logic [10:0] idx_q;
   logic [3:0]  lx_q, ly_q, lx2_q, ly2_q;
   logic        inr_q, inr2_q;
   logic [1:0]  code_q;
   logic [7:0]  colour_q, colour_d;
   logic [5:0]  col;
   logic [4:0]  row;
   logic        in_range, edge_px;

   assign WR_READY = (state_q == ST_IDLE);
   assign COLOUR   = colour_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we      = 1'b0;
      wa      = 11'(WR_Y) * 11'd40 + 11'(WR_X);
      wd      = WR_DATA;
      if (state_q == ST_IDLE) begin
         if (CLEAR) begin
            state_d = ST_CLEAR;
            cnt_d   = 11'd0;
         end else
            we = WR_EN && (WR_X < 6'd40) && (WR_Y < 5'd30);
      end else begin
         we      = 1'b1;
         wa      = cnt_q;
         wd      = 2'd0;
         cnt_d   = (cnt_q == 11'd1199) ? 11'd0 : cnt_q + 11'd1;
         state_d = (cnt_q == 11'd1199) ? ST_IDLE : ST_CLEAR;
      end
   end

   // Reset parks the FSM in CLEAR at index 0 so the sweep starts on release.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= ST_CLEAR;
         cnt_q   <= 11'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge CLK)
      if (we && !RESET) mem[wa] <= wd;

   assign col      = ADDRH[9:4];
   assign row      = ADDRV[8:4];
   assign in_range = (col < 6'd40) && (row < 5'd30);
   assign edge_px  = (&lx2_q) || (~|lx2_q) || (&ly2_q) || (~|ly2_q);

   always_comb
      colour_d = !inr2_q                        ? 8'h00 :
                 (code_q != 2'd0 && edge_px)    ? COL_EDGE :
                 (code_q == 2'd1)               ? COL_BODY :
                 (code_q == 2'd2)               ? COL_HEAD :
                 (code_q == 2'd3)               ? COL_FOOD : COL_EMPTY;

   // Off-map pixels read index 0; their colour is forced to black in S3.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         idx_q    <= 11'd0;
         lx_q     <= 4'd0;
         ly_q     <= 4'd0;
         inr_q    <= 1'b0;
         code_q   <= 2'd0;
         lx2_q    <= 4'd0;
         ly2_q    <= 4'd0;
         inr2_q   <= 1'b0;
         colour_q <= 8'h00;
      end else begin
         idx_q    <= in_range ? 11'(row) * 11'd40 + 11'(col) : 11'd0;
         lx_q     <= ADDRH[3:0];
         ly_q     <= ADDRV[3:0];
         inr_q    <= in_range;
         code_q   <= mem[idx_q];
         lx2_q    <= lx_q;
         ly2_q    <= ly_q;
         inr2_q   <= inr_q;
         colour_q <= colour_d;
      end
   end
endmodule

// File: tb/tb_tile_colour_renderer.sv
// tb_tile_colour_renderer: scoreboard bench with a tile-map reference model.
module tb_tile_colour_renderer;
   localparam logic [7:0] C_EMPTY = 8'h00, C_BODY = 8'h1C, C_HEAD = 8'h1F,
                          C_FOOD = 8'hE0, C_EDGE = 8'h92;
   logic       CLK = 0, RESET = 1, WR_EN = 0, CLEAR = 0;
   logic [9:0] ADDRH = 0;
   logic [8:0] ADDRV = 0;
   logic [5:0] WR_X = 0;
   logic [4:0] WR_Y = 0;
   logic [1:0] WR_DATA = 0;
   logic [7:0] COLOUR;
   logic       WR_READY;
   int         vectors = 0, miscompares = 0;
   logic [1:0] model [0:1199];
   logic [7:0] sb [$];

   tile_colour_renderer dut (
      .CLK(CLK), .RESET(RESET), .ADDRH(ADDRH), .ADDRV(ADDRV), .COLOUR(COLOUR),
      .WR_EN(WR_EN), .WR_X(WR_X), .WR_Y(WR_Y), .WR_DATA(WR_DATA),
      .CLEAR(CLEAR), .WR_READY(WR_READY)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [7:0] exp_col(input logic [9:0] h, input logic [8:0] v);
      int c = int'(h[9:4]), r = int'(v[8:4]);
      logic [1:0] code;
      if (c >= 40 || r >= 30) return 8'h00;
      code = model[r * 40 + c];
      if (code != 0 && (h[3:0] == 0 || h[3:0] == 15 || v[3:0] == 0 || v[3:0] == 15)) return C_EDGE;
      return code == 1 ? C_BODY : code == 2 ? C_HEAD : code == 3 ? C_FOOD : C_EMPTY;
   endfunction

   // Each applied pixel pushes its expectation; the one from 3 edges ago is popped.
   task automatic apply_pix(input string tag, input logic [9:0] h, input logic [8:0] v);
      logic [7:0] e;
      ADDRH = h;
      ADDRV = v;
      sb.push_back(exp_col(h, v));
      tick();
      if (sb.size() == 3) begin
         e = sb.pop_front();
         check(tag, {24'd0, COLOUR}, {24'd0, e});
      end
   endtask

   task automatic burst_end();
      apply_pix("pad", ADDRH, ADDRV);
      apply_pix("pad", ADDRH, ADDRV);
      sb.delete();
   endtask

   task automatic scan_all(input string tag);
      sb.delete();
      for (int i = 0; i < 1200; i++)
         apply_pix(tag, {i[5:0] % 6'd40 == i[5:0] ? 6'(i % 40) : 6'(i % 40), 4'($urandom_range(0, 15))},
                        {5'(i / 40), 4'($urandom_range(0, 15))});
      burst_end();
   endtask

   task automatic wr(input logic [5:0] x, input logic [4:0] y, input logic [1:0] d, input logic c);
      WR_EN = 1;
      WR_X = x;
      WR_Y = y;
      WR_DATA = d;
      CLEAR = c;
      tick();
      WR_EN = 0;
      CLEAR = 0;
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!WR_READY && n < 3000) begin
         tick();
         n++;
      end
      check(tag, n, 1200);
   endtask

   initial begin
      for (int i = 0; i < 1200; i++) model[i] = 2'd0;
      repeat (3) tick();
      check("rst_colour", {24'd0, COLOUR}, 0);
      check("rst_ready", {31'd0, WR_READY}, 0);
      RESET = 0;
      check("rel_ready", {31'd0, WR_READY}, 0);
      wait_ready("boot_sweep_len");
      check("boot_ready", {31'd0, WR_READY}, 1);
      scan_all("boot_empty");

      check("idle_ready", {31'd0, WR_READY}, 1);
      wr(6'd3, 5'd2, 2'd2, 1'b0);
      model[2 * 40 + 3] = 2'd2;
      sb.delete();
      apply_pix("head_centre", 10'd56, 9'd40);
      apply_pix("head_edge", 10'd48, 9'd40);
      apply_pix("head_bottom", 10'd56, 9'd47);
      apply_pix("head_right", 10'd63, 9'd36);
      burst_end();

      wr(6'd39, 5'd29, 2'd3, 1'b0);
      model[29 * 40 + 39] = 2'd3;
      sb.delete();
      apply_pix("food_corner", 10'd639, 9'd479);
      apply_pix("food_inner", 10'd632, 9'd472);
      apply_pix("off_h", 10'd640, 9'd40);
      apply_pix("off_v", 10'd56, 9'd480);
      apply_pix("off_max", 10'd1023, 9'd511);
      burst_end();

      wr(6'd10, 5'd5, 2'd1, 1'b0);
      model[5 * 40 + 10] = 2'd1;
      wr(6'd40, 5'd0, 2'd1, 1'b0);
      wr(6'd0, 5'd30, 2'd2, 1'b0);
      wr(6'd63, 5'd31, 2'd3, 1'b0);
      scan_all("map_after_writes");

      wr(6'd0, 5'd0, 2'd0, 1'b1);
      WR_EN = 0;
      check("clr_ready_low", {31'd0, WR_READY}, 0);
      wait_ready("clr_sweep_len");
      for (int i = 0; i < 1200; i++) model[i] = 2'd0;
      scan_all("clr_empty");

      wr(6'd39, 5'd29, 2'd3, 1'b0);
      ADDRH = 10'd632;
      ADDRV = 9'd472;
      wr(6'd39, 5'd29, 2'd1, 1'b1);
      check("clr_wr_ready", {31'd0, WR_READY}, 0);
      repeat (300) tick();
      wr(6'd39, 5'd28, 2'd2, 1'b0);
      ADDRV = 9'd456;
      repeat (3) tick();
      check("clr_ignores_wr", {24'd0, COLOUR}, {24'd0, C_EMPTY});
      ADDRV = 9'd472;
      repeat (293) tick();
      check("clr_dropped_wr", {24'd0, COLOUR}, {24'd0, C_FOOD});
      RESET = 1;
      tick();
      check("mid_rst_colour", {24'd0, COLOUR}, 0);
      check("mid_rst_ready", {31'd0, WR_READY}, 0);
      RESET = 0;
      wait_ready("restart_sweep_len");
      scan_all("restart_empty");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/tile_colour_renderer.md
TILE_COLOUR_RENDERER -- requirements
Module: tile_colour_renderer

Interface
REQ-001 SHALL have parameter COL_EMPTY, default 8'h00, colour of an empty tile.
REQ-002 SHALL have parameter COL_BODY, default 8'h1C, colour of a snake-body tile.
REQ-003 SHALL have parameter COL_HEAD, default 8'h1F, colour of a snake-head tile.
REQ-004 SHALL have parameter COL_FOOD, default 8'hE0, colour of a food tile.
REQ-005 SHALL have parameter COL_EDGE, default 8'h92, outline colour of any non-empty tile.
REQ-006 SHALL have port CLK  input  1  the single clock; all logic on its rising edge.
REQ-007 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-008 SHALL have port ADDRH  input  10  horizontal pixel address from the VGA timing stage, 0..639.
REQ-009 SHALL have port ADDRV  input  9  vertical pixel address from the VGA timing stage, 0..479.
REQ-010 SHALL have port COLOUR  output  8  registered pixel colour driven into the VGA stage's colour input.
REQ-011 SHALL have port WR_EN  input  1  game-logic tile write strobe.
REQ-012 SHALL have port WR_X  input  6  tile column, 0..39.
REQ-013 SHALL have port WR_Y  input  5  tile row, 0..29.
REQ-014 SHALL have port WR_DATA  input  2  tile code: 0 empty, 1 body, 2 head, 3 food.
REQ-015 SHALL have port CLEAR  input  1  request to set every tile to empty.
REQ-016 SHALL have port WR_READY  output  1  high when writes are accepted (state IDLE).

Function
REQ-017 SHALL store a 40x30 map of 2-bit tile codes (1200 entries), linear index = row*40 + column, one write port and one synchronous read port.
REQ-018 SHALL map pixel to tile: column = ADDRH[9:4], row = ADDRV[8:4], in-tile offsets lx = ADDRH[3:0], ly = ADDRV[3:0].
REQ-019 SHALL pipeline lookup in 3 stages: S1 registers index, offsets, in-range flag; S2 reads map; S3 registers COLOUR -- COLOUR at cycle n+3 corresponds to ADDRH/ADDRV sampled at cycle n, fixed, no bubbles.
REQ-020 SHALL output COL_EDGE when tile code != 0 and (lx == 0 or ly == 0 or lx == 15 or ly == 15).
REQ-021 SHALL otherwise output the palette colour selected by the tile code.
REQ-022 SHALL output 8'h00 when column >= 40 or row >= 30, regardless of map content.
REQ-023 SHALL implement FSM states IDLE and CLEAR; WR_READY = 1 only in IDLE.
REQ-024 SHALL in IDLE, when WR_EN = 1, WR_X < 40, WR_Y < 30 and CLEAR = 0, write WR_DATA at that tile on the same edge.
REQ-025 SHALL silently drop writes with WR_X >= 40 or WR_Y >= 30.
REQ-026 SHALL in IDLE with CLEAR = 1 go to CLEAR; CLEAR wins over a simultaneous WR_EN, and that write is dropped.
REQ-027 SHALL in CLEAR write 0 to index k on the k-th cycle, k = 0..1199, then return to IDLE; duration exactly 1200 cycles.
REQ-028 SHALL ignore WR_EN and CLEAR while in CLEAR; a CLEAR pulse does not restart the sweep.
REQ-029 SHALL on a read/write to the same index on the same cycle return the old (pre-write) data.
REQ-030 SHALL keep the render pipeline running in all FSM states; during CLEAR it shows a mix of old and cleared tiles.

Reset
REQ-031 SHALL on RESET = 1 drive COLOUR = 8'h00, clear all pipeline registers and set the clear counter to 0.
REQ-032 SHALL enter CLEAR on the first cycle after RESET deasserts, so WR_READY = 0 for 1200 cycles after reset, then 1.
REQ-033 SHALL on RESET asserted mid-CLEAR abort the sweep and restart it from index 0 after deassertion.

Verification
REQ-034 SHALL pass: release RESET -> WR_READY low exactly 1200 cycles, then high; every tile renders COL_EMPTY.
REQ-035 SHALL pass: write code 2 at (3,2), then drive ADDRH=56, ADDRV=40 -> COLOUR = COL_HEAD 3 cycles later; ADDRH=48, ADDRV=40 -> COL_EDGE.
REQ-036 SHALL pass: drive ADDRH=639, ADDRV=479 after writing code 3 at (39,29) -> COL_EDGE; ADDRH=632, ADDRV=472 -> COL_FOOD.
REQ-037 SHALL pass: WR_EN with WR_X=40, WR_Y=0, WR_DATA=1 -> no map entry changes; all 1200 tiles still empty.
REQ-038 SHALL pass: CLEAR and WR_EN on same cycle in IDLE -> write dropped, WR_READY low next cycle for 1200 cycles.
REQ-039 SHALL pass: assert RESET at clear cycle 600 -> COLOUR = 8'h00 next cycle; full 1200-cycle sweep restarts after release.
